// File: rtl/ysyx_22040931_idecode_pipe_if.sv
`default_nettype none
// IFU -> IDU -> EXU handshake bundle for the registered I-type decode stage.
// The slave side is the decode stage; the master side drives instructions in and consumes results.
interface ysyx_22040931_idecode_pipe_if #(
  parameter int XLEN = 64
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic            out_itype;
  logic [2:0]      out_exop;
  logic [4:0]      out_aluop;
  logic [2:0]      out_memrop;
  logic            out_jump;
  logic            out_illegal;
  logic [XLEN-1:0] out_imm;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [XLEN-1:0] out_pc;

  modport slave (
    input  flush, in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_itype, out_exop, out_aluop, out_memrop,
           out_jump, out_illegal, out_imm, out_rd, out_rs1, out_pc
  );

  modport master (
    output flush, in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_itype, out_exop, out_aluop, out_memrop,
           out_jump, out_illegal, out_imm, out_rd, out_rs1, out_pc
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_22040931_idecode_pipe.sv
`default_nettype none
// Registered I-type decode stage: OP-IMM, OP-IMM-32, LOAD, JALR, ecall/ebreak decode,
// immediate generation and illegal-field detection behind a one-entry valid/ready register.
module ysyx_22040931_idecode_pipe #(
  parameter int XLEN = 64,
  parameter bit RV64 = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst,
  ysyx_22040931_idecode_pipe_if.slave         bus
);

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  localparam logic [2:0] EX_NONE   = 3'd0;
  localparam logic [2:0] EX_ARITH  = 3'd1;
  localparam logic [2:0] EX_SHORT  = 3'd2;
  localparam logic [2:0] EX_LOAD   = 3'd3;
  localparam logic [2:0] EX_SYSTEM = 3'd4;

  localparam logic [4:0] ALU_NO    = 5'd0;
  localparam logic [4:0] ALU_ADD   = 5'd1;
  localparam logic [4:0] ALU_AND   = 5'd2;
  localparam logic [4:0] ALU_OR    = 5'd3;
  localparam logic [4:0] ALU_XOR   = 5'd4;
  localparam logic [4:0] ALU_SHIL  = 5'd5;
  localparam logic [4:0] ALU_SHIR  = 5'd6;
  localparam logic [4:0] ALU_SRA   = 5'd7;
  localparam logic [4:0] ALU_COM   = 5'd8;
  localparam logic [4:0] ALU_COMU  = 5'd9;
  localparam logic [4:0] ALU_JUMP  = 5'd10;
  localparam logic [4:0] ALU_SHILW = 5'd11;
  localparam logic [4:0] ALU_SHIRW = 5'd12;
  localparam logic [4:0] ALU_SRAW  = 5'd13;

  localparam logic [2:0] MEM_NO  = 3'd0;
  localparam logic [2:0] MEM_LB  = 3'd1;
  localparam logic [2:0] MEM_LH  = 3'd2;
  localparam logic [2:0] MEM_LW  = 3'd3;
  localparam logic [2:0] MEM_LD  = 3'd4;
  localparam logic [2:0] MEM_LBU = 3'd5;
  localparam logic [2:0] MEM_LHU = 3'd6;
  localparam logic [2:0] MEM_LWU = 3'd7;

  localparam logic [5:0] F6_SRL = 6'b000000;
  localparam logic [5:0] F6_SRA = 6'b010000;
  localparam logic [6:0] F7_SRL = 7'b0000000;
  localparam logic [6:0] F7_SRA = 7'b0100000;

  localparam int IMM_PAD = XLEN - 12;

  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [5:0]  funct6;
  logic        shamt_hi_ok;

  assign inst   = bus.in_inst;
  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign funct6 = inst[31:26];

  // RV32 shift amounts are 5 bits, so inst[25] becomes part of the funct field.
  assign shamt_hi_ok = RV64 | ~inst[25];

  logic       hit;
  logic       bad;
  logic [2:0] dec_exop;
  logic [4:0] dec_aluop;
  logic [2:0] dec_memrop;
  logic       dec_jump;

  always_comb begin
    hit        = 1'b0;
    bad        = 1'b0;
    dec_exop   = EX_NONE;
    dec_aluop  = ALU_NO;
    dec_memrop = MEM_NO;
    dec_jump   = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin
        hit      = 1'b1;
        dec_exop = EX_ARITH;
        case (funct3)
          3'b000: dec_aluop = ALU_ADD;
          3'b010: dec_aluop = ALU_COM;
          3'b011: dec_aluop = ALU_COMU;
          3'b100: dec_aluop = ALU_XOR;
          3'b110: dec_aluop = ALU_OR;
          3'b111: dec_aluop = ALU_AND;
          3'b001: begin
            dec_aluop = ALU_SHIL;
            bad       = (funct6 != 6'b000000) | ~shamt_hi_ok;
          end
          3'b101: begin
            if (funct6 == F6_SRL) begin
              dec_aluop = ALU_SHIR;
            end else if (funct6 == F6_SRA) begin
              dec_aluop = ALU_SRA;
            end else begin
              bad = 1'b1;
            end
            if (!shamt_hi_ok) begin
              bad = 1'b1;
            end
          end
        endcase
      end
      OPC_OP_IMM32: begin
        hit = 1'b1;
        if (!RV64) begin
          bad = 1'b1;
        end else begin
          case (funct3)
            3'b000: begin
              dec_exop  = EX_SHORT;
              dec_aluop = ALU_ADD;
            end
            3'b001: begin
              dec_exop  = EX_SHORT;
              dec_aluop = ALU_SHILW;
              bad       = (funct7 != 7'b0000000);
            end
            3'b101: begin
              // Word right shifts go to the Arith unit; the W-variant aluop carries the width.
              dec_exop = EX_ARITH;
              if (funct7 == F7_SRL) begin
                dec_aluop = ALU_SHIRW;
              end else if (funct7 == F7_SRA) begin
                dec_aluop = ALU_SRAW;
              end else begin
                bad = 1'b1;
              end
            end
            default: bad = 1'b1;
          endcase
        end
      end
      OPC_LOAD: begin
        hit       = 1'b1;
        dec_exop  = EX_LOAD;
        dec_aluop = ALU_ADD;
        case (funct3)
          3'b000: dec_memrop = MEM_LB;
          3'b001: dec_memrop = MEM_LH;
          3'b010: dec_memrop = MEM_LW;
          3'b011: begin
            dec_memrop = MEM_LD;
            bad        = ~RV64;
          end
          3'b100: dec_memrop = MEM_LBU;
          3'b101: dec_memrop = MEM_LHU;
          3'b110: begin
            dec_memrop = MEM_LWU;
            bad        = ~RV64;
          end
          3'b111: bad = 1'b1;
        endcase
      end
      OPC_JALR: begin
        hit = 1'b1;
        if (funct3 == 3'b000) begin
          dec_exop  = EX_ARITH;
          dec_aluop = ALU_JUMP;
          dec_jump  = 1'b1;
        end else begin
          bad = 1'b1;
        end
      end
      OPC_SYSTEM: begin
        // Only ecall/ebreak are I-type here; CSR and other SYSTEM words are simply not ours.
        if (inst == INST_ECALL || inst == INST_EBREAK) begin
          hit       = 1'b1;
          dec_exop  = EX_SYSTEM;
          dec_aluop = ALU_NO;
        end
      end
      default: begin
        hit = 1'b0;
      end
    endcase
  end

  logic            accept;
  logic [XLEN-1:0] imm;

  assign bus.in_ready = ~bus.out_valid | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;
  assign imm          = {{IMM_PAD{inst[31]}}, inst[31:20]};

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid   <= 1'b0;
      bus.out_itype   <= 1'b0;
      bus.out_illegal <= 1'b0;
      bus.out_exop    <= EX_NONE;
      bus.out_aluop   <= ALU_NO;
      bus.out_memrop  <= MEM_NO;
      bus.out_jump    <= 1'b0;
      bus.out_imm     <= '0;
      bus.out_rd      <= '0;
      bus.out_rs1     <= '0;
      bus.out_pc      <= '0;
    end else begin
      if (bus.flush) begin
        bus.out_valid <= 1'b0;
      end else if (accept) begin
        bus.out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
      // Payload may load under flush; it is don't-care while out_valid is low.
      if (accept) begin
        bus.out_itype   <= hit & ~bad;
        bus.out_illegal <= bad;
        bus.out_exop    <= bad ? EX_NONE : dec_exop;
        bus.out_aluop   <= bad ? ALU_NO  : dec_aluop;
        bus.out_memrop  <= bad ? MEM_NO  : dec_memrop;
        bus.out_jump    <= dec_jump & ~bad;
        bus.out_imm     <= imm;
        bus.out_rd      <= inst[11:7];
        bus.out_rs1     <= inst[19:15];
        bus.out_pc      <= bus.in_pc;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040931_idecode_pipe.sv
`default_nettype none
// Bench for the I-type decode stage: a mask/match instruction table model drives a per-cycle
// compare of an RV64 and an RV32 instance run in lockstep, plus literal spot checks.
module tb_ysyx_22040931_idecode_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_22040931_idecode_pipe_if #(.XLEN(64)) bus ();
  ysyx_22040931_idecode_pipe_if #(.XLEN(32)) bus32 ();

  assign bus32.flush     = bus.flush;
  assign bus32.in_valid  = bus.in_valid;
  assign bus32.in_inst   = bus.in_inst;
  assign bus32.in_pc     = bus.in_pc[31:0];
  assign bus32.out_ready = bus.out_ready;

  ysyx_22040931_idecode_pipe #(.XLEN(64), .RV64(1'b1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ysyx_22040931_idecode_pipe #(.XLEN(32), .RV64(1'b0)) u_dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       itype;
    logic       illegal;
    logic [2:0] exop;
    logic [4:0] aluop;
    logic [2:0] memrop;
    logic       jump;
  } ctl_t;

  typedef struct packed {
    logic [31:0] mask;
    logic [31:0] match;
    logic        rv64only;
    logic        rv32only;
    logic [2:0]  exop;
    logic [4:0]  aluop;
    logic [2:0]  memrop;
    logic        jump;
  } entry_t;

  localparam int NENT = 26;

  function automatic entry_t mk(logic [31:0] m, logic [31:0] v, logic r64, logic r32,
                                logic [2:0] ex, logic [4:0] al, logic [2:0] mr, logic j);
    entry_t e;
    e = '{mask: m, match: v, rv64only: r64, rv32only: r32, exop: ex, aluop: al, memrop: mr, jump: j};
    return e;
  endfunction

  // Instruction table in mask/match form, one row per legal mnemonic.
  function automatic entry_t tbl(int i);
    logic [2:0] f3;
    f3 = 3'(i - 16);
    case (i)
      0:  return mk(32'h0000707F, 32'h00000013, 0, 0, 1, 1, 0, 0);   // addi
      1:  return mk(32'h0000707F, 32'h00002013, 0, 0, 1, 8, 0, 0);   // slti
      2:  return mk(32'h0000707F, 32'h00003013, 0, 0, 1, 9, 0, 0);   // sltiu
      3:  return mk(32'h0000707F, 32'h00004013, 0, 0, 1, 4, 0, 0);   // xori
      4:  return mk(32'h0000707F, 32'h00006013, 0, 0, 1, 3, 0, 0);   // ori
      5:  return mk(32'h0000707F, 32'h00007013, 0, 0, 1, 2, 0, 0);   // andi
      6:  return mk(32'hFC00707F, 32'h00001013, 1, 0, 1, 5, 0, 0);   // slli rv64
      7:  return mk(32'hFC00707F, 32'h00005013, 1, 0, 1, 6, 0, 0);   // srli rv64
      8:  return mk(32'hFC00707F, 32'h40005013, 1, 0, 1, 7, 0, 0);   // srai rv64
      9:  return mk(32'hFE00707F, 32'h00001013, 0, 1, 1, 5, 0, 0);   // slli rv32
      10: return mk(32'hFE00707F, 32'h00005013, 0, 1, 1, 6, 0, 0);   // srli rv32
      11: return mk(32'hFE00707F, 32'h40005013, 0, 1, 1, 7, 0, 0);   // srai rv32
      12: return mk(32'h0000707F, 32'h0000001B, 1, 0, 2, 1, 0, 0);   // addiw
      13: return mk(32'hFE00707F, 32'h0000101B, 1, 0, 2, 11, 0, 0);  // slliw
      14: return mk(32'hFE00707F, 32'h0000501B, 1, 0, 1, 12, 0, 0);  // srliw
      15: return mk(32'hFE00707F, 32'h4000501B, 1, 0, 1, 13, 0, 0);  // sraiw
      23: return mk(32'h0000707F, 32'h00000067, 0, 0, 1, 10, 0, 1);  // jalr
      24: return mk(32'hFFFFFFFF, 32'h00000073, 0, 0, 4, 0, 0, 0);   // ecall
      25: return mk(32'hFFFFFFFF, 32'h00100073, 0, 0, 4, 0, 0, 0);   // ebreak
      default: return mk(32'h0000707F, {17'd0, f3, 12'h003},
                         logic'(f3 == 3'd3 || f3 == 3'd6), 0, 3, 1, 3'(f3 + 3'd1), 0); // loads
    endcase
  endfunction

  function automatic ctl_t model_decode(logic [31:0] inst, bit rv64);
    ctl_t   r;
    entry_t e;
    bit     found;
    r     = '0;
    found = 0;
    for (int i = 0; i < NENT; i++) begin
      e = tbl(i);
      if (!found && (inst & e.mask) == e.match &&
          !(e.rv64only && !rv64) && !(e.rv32only && rv64)) begin
        found    = 1;
        r.itype  = 1'b1;
        r.exop   = e.exop;
        r.aluop  = e.aluop;
        r.memrop = e.memrop;
        r.jump   = e.jump;
      end
    end
    if (!found && (inst[6:0] == 7'h13 || inst[6:0] == 7'h1B ||
                   inst[6:0] == 7'h03 || inst[6:0] == 7'h67))
      r.illegal = 1'b1;
    return r;
  endfunction

  logic        m_valid = 1'b0;
  logic        m_acc   = 1'b0;
  logic        started = 1'b0;
  ctl_t        m64, m32;
  logic [31:0] m_inst;
  logic [63:0] m_pc;

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      m_valid = 1'b0;
      m_acc   = 1'b0;
    end else begin
      m_acc = bus.in_valid && (!m_valid || bus.out_ready);
      if (m_acc) begin
        m64    = model_decode(bus.in_inst, 1'b1);
        m32    = model_decode(bus.in_inst, 1'b0);
        m_inst = bus.in_inst;
        m_pc   = bus.in_pc;
      end
      if (bus.flush)        m_valid = 1'b0;
      else if (m_acc)       m_valid = 1'b1;
      else if (bus.out_ready) m_valid = 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      chk("out_valid",   64'(bus.out_valid),   64'(m_valid));
      chk("in_ready",    64'(bus.in_ready),    64'(!m_valid || bus.out_ready));
      chk("out_valid32", 64'(bus32.out_valid), 64'(m_valid));
      if (m_valid) begin
        chk("ctl64", 64'({bus.out_itype, bus.out_illegal, bus.out_exop, bus.out_aluop,
                          bus.out_memrop, bus.out_jump}), 64'(m64));
        chk("imm64", bus.out_imm, {{52{m_inst[31]}}, m_inst[31:20]});
        chk("rd_rs1", 64'({bus.out_rd, bus.out_rs1}), 64'({m_inst[11:7], m_inst[19:15]}));
        chk("pc64", bus.out_pc, m_pc);
        chk("ctl32", 64'({bus32.out_itype, bus32.out_illegal, bus32.out_exop, bus32.out_aluop,
                          bus32.out_memrop, bus32.out_jump}), 64'(m32));
        chk("imm32", 64'(bus32.out_imm), 64'({{20{m_inst[31]}}, m_inst[31:20]}));
        chk("pc32", 64'(bus32.out_pc), 64'(m_pc[31:0]));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  int cyc = 0;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    bus.in_pc = bus.in_pc + 64'd4;
  endtask

  logic [31:0] vecs [12];
  logic [63:0] held_pc;

  initial begin
    vecs = '{32'h0010809B, 32'h0010909B, 32'h0010D09B, 32'h4010D09B,
             32'h0210909B, 32'h0000B283, 32'h0000E283, 32'h0000F283,
             32'h000290E7, 32'h00000073, 32'h02009093, 32'h000010B7};
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_inst   = 32'hFFF00093;
    bus.in_pc     = 64'h8000_0000;
    bus.out_ready = 1'b1;
    step();
    step();
    chk("reset_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_regs", {bus.out_imm[31:0], 27'd0, bus.out_itype, bus.out_exop, bus.out_jump}, 64'd0);
    rst = 1'b0;
    step();
    chk("addi_lit", 64'({bus.out_valid, bus.out_itype, bus.out_exop, bus.out_aluop, bus.out_rd}),
        64'({1'b1, 1'b1, 3'd1, 5'd1, 5'd1}));
    chk("addi_imm", bus.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);

    for (int f = 0; f < 7; f++) begin
      bus.in_inst = 32'h00008283 | (32'(f) << 12);
      step();
      chk("load_memrop", 64'({bus.out_exop, bus.out_memrop}), 64'({3'd3, 3'(f + 1)}));
    end
    chk("lwu_rv32_illegal", 64'({bus32.out_illegal, bus32.out_itype}), 64'b10);

    bus.in_inst = 32'h43F15113;
    step();
    chk("srai_lit", 64'({bus.out_aluop, bus.out_imm[5:0]}), 64'({5'd7, 6'd63}));
    bus.in_inst = 32'h47F15113;
    step();
    chk("srai_bad", 64'({bus.out_illegal, bus.out_itype}), 64'b10);

    bus.in_inst = 32'h000280E7;
    step();
    held_pc       = bus.in_pc - 64'd4;
    bus.out_ready = 1'b0;
    bus.in_inst   = 32'h00A00193;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("jalr_hold", 64'({bus.in_ready, bus.out_valid, bus.out_jump, bus.out_aluop}),
          64'({1'b0, 1'b1, 1'b1, 5'd10}));
      chk("jalr_pc", bus.out_pc, held_pc);
    end
    bus.out_ready = 1'b1;
    step();
    chk("after_hold", 64'({bus.out_valid, bus.out_rd, bus.out_aluop}), 64'({1'b1, 5'd3, 5'd1}));

    bus.flush   = 1'b1;
    bus.in_inst = 32'h00500213;
    step();
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    bus.flush   = 1'b0;
    bus.in_inst = 32'h00100073;
    step();
    chk("ebreak_lit", 64'({bus.out_valid, bus.out_itype, bus.out_exop, bus.out_aluop}),
        64'({1'b1, 1'b1, 3'd4, 5'd0}));
    bus.in_inst = 32'h00200073;
    step();
    chk("sys_other", 64'({bus.out_valid, bus.out_itype, bus.out_illegal}), 64'b100);
    bus.in_inst = 32'h00000033;
    step();
    chk("rtype", 64'({bus.out_valid, bus.out_itype, bus.out_illegal}), 64'b100);

    for (int i = 0; i < 12; i++) begin
      int n;
      n           = 0;
      bus.in_inst = vecs[i];
      do begin
        bus.out_ready = (cyc % 3 != 2);
        step();
        n++;
      end while (!m_acc && n < 10);
      if (!m_acc) chk("accept_timeout", 64'd0, 64'd1);
    end

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    chk("drain", 64'({bus.out_valid, bus.in_ready}), 64'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
